serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_pkg.sv | 17 +
 rtl/serial_add_if.sv | 36 +++
 rtl/serial_fa_cell.sv | 16 +
 rtl/serial_add_ctrl.sv | 98 +++++++++
 tb/tb_serial_add_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types, default width and counter sizing for the serial adder
package serial_add_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Bit counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice
   function automatic int cnt_width(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/serial_add_if.sv
// rtl/serial_add_if.sv - operand/result handshake bundle (carry_in present when SERIAL_ADD_CIN_EN is defined)
interface serial_add_if
   import serial_add_pkg::*;
   #(parameter int WIDTH = DEFAULT_WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
`ifdef SERIAL_ADD_CIN_EN
   logic             carry_in;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry_out;

   // Requester side: supplies operands, takes results
   modport master (
      output in_valid, op_a, op_b, out_ready,
`ifdef SERIAL_ADD_CIN_EN
      output carry_in,
`endif
      input  in_ready, out_valid, result, carry_out
   );

   // Adder side
   modport slave (
      input  in_valid, op_a, op_b, out_ready,
`ifdef SERIAL_ADD_CIN_EN
      input  carry_in,
`endif
      output in_ready, out_valid, result, carry_out
   );

endinterface

// File: rtl/serial_fa_cell.sv
// rtl/serial_fa_cell.sv - combinational one-bit full adder cell
module serial_fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   // Plain majority/parity full adder
   always_comb begin
      sum  = a ^ b ^ cin;
      cout = (a & b) | (a & cin) | (b & cin);
   end

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller, LSB first; SERIAL_ADD_CIN_EN adds a carry_in input
module serial_add_ctrl
   import serial_add_pkg::*;
   #(parameter int WIDTH = DEFAULT_WIDTH)
(
   input  logic        clk,
   input  logic        rst,
   serial_add_if.slave bus
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_q;
   logic [CW-1:0]    cnt;
   logic             carry_q;
   logic             cout_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             sum;
   logic             carry_n;
   logic             cin_load;

   // Single cell, time-multiplexed over all bit positions
   serial_fa_cell u_cell (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry_q),
      .sum  (sum),
      .cout (carry_n)
   );

`ifdef SERIAL_ADD_CIN_EN
   assign cin_load = bus.carry_in;
`else
   assign cin_load = 1'b0;
`endif

   // Control FSM with registered handshake outputs; result shifts in from the MSB side
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         a_sr        <= '0;
         b_sr        <= '0;
         res_q       <= '0;
         cnt         <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_sr       <= bus.op_a;
                  b_sr       <= bus.op_b;
                  cnt        <= '0;
                  carry_q    <= cin_load;
                  in_ready_q <= 1'b0;
                  state      <= SHIFT;
               end
            end
            SHIFT: begin
               res_q   <= {sum, res_q[WIDTH-1:1]};
               a_sr    <= a_sr >> 1;
               b_sr    <= b_sr >> 1;
               carry_q <= carry_n;
               cnt     <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  cout_q      <= carry_n;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = res_q;
   assign bus.carry_out = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl (define SERIAL_ADD_CIN_EN for carry_in cases)
module tb_serial_add_ctrl;
   import serial_add_pkg::*;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;

   int vectors     = 0;
   int miscompares = 0;

   logic [W:0] sb [$];

   serial_add_if #(.WIDTH(W)) bus ();

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present operands, wait (bounded) for in_ready, return just after the accepting edge
   task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      int n;
      logic ce;
      n = 0;
      bus.in_valid = 1'b1;
      bus.op_a     = a;
      bus.op_b     = b;
`ifdef SERIAL_ADD_CIN_EN
      bus.carry_in = c;
      ce = c;
`else
      ce = 1'b0;
      if (c) ce = 1'b0;
`endif
      while (!bus.in_ready && n < 50) begin
         tick();
         n++;
      end
      check("accept_wait", 64'(n < 50), 64'd1);
      tick();
      sb.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, ce});
      bus.in_valid = 1'b0;
   endtask

   // Wait for the result, optionally stall it and/or toggle in_valid during SHIFT, then compare
   task automatic finish_add(input int hold, input bit toggle);
      int edges;
      logic [W-1:0] r0;
      logic c0;
      logic [W:0] exp;
      edges = 1;
      bus.out_ready = (hold == 0);
      while (!bus.out_valid && edges < 100) begin
         check("in_ready_shift", 64'(bus.in_ready), 64'd0);
         if (toggle) begin
            bus.in_valid = ~bus.in_valid;
            bus.op_a     = W'($urandom);
            bus.op_b     = W'($urandom);
         end
         tick();
         edges++;
      end
      bus.in_valid = 1'b0;
      // edges counts the accepting edge as the first one
      check("latency", 64'(edges), 64'(W + 1));
      r0 = bus.result;
      c0 = bus.carry_out;
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = 1'b1;
         bus.op_a     = 8'h11;
         bus.op_b     = 8'h22;
         tick();
         check("hold_valid", 64'(bus.out_valid), 64'd1);
         check("hold_result", 64'(bus.result), 64'(r0));
         check("hold_carry", 64'(bus.carry_out), 64'(c0));
         check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
      check("out_valid", 64'(bus.out_valid), 64'd1);
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
         exp = sb.pop_front();
         check("result", 64'(bus.result), 64'(exp[W-1:0]));
         check("carry_out", 64'(bus.carry_out), 64'(exp[W]));
      end
      tick();
      check("out_valid_drop", 64'(bus.out_valid), 64'd0);
      check("in_ready_idle", 64'(bus.in_ready), 64'd1);
      bus.out_ready = 1'b0;
   endtask

   // Directed scenarios followed by a short random sweep
   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.out_ready = 1'b0;
`ifdef SERIAL_ADD_CIN_EN
      bus.carry_in  = 1'b0;
`endif
      repeat (2) tick();
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_result", 64'(bus.result), 64'd0);
      check("rst_carry", 64'(bus.carry_out), 64'd0);
      rst = 1'b0;

      start(8'h00, 8'h00, 1'b0);
      finish_add(0, 1'b0);
      start(8'hFF, 8'h01, 1'b0);
      finish_add(0, 1'b0);
      start(8'h5A, 8'h33, 1'b0);
      finish_add(0, 1'b0);

      start(8'hC3, 8'h7E, 1'b0);
      finish_add(5, 1'b0);
      start(8'h11, 8'h22, 1'b0);
      finish_add(0, 1'b0);

      start(8'h9C, 8'hA5, 1'b0);
      finish_add(0, 1'b1);

      start(8'h77, 8'h66, 1'b0);
      repeat (3) tick();
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("mid_rst_result", 64'(bus.result), 64'd0);
      check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("mid_rst_carry", 64'(bus.carry_out), 64'd0);
      void'(sb.pop_back());
      #2;
      rst = 1'b0;
      start(8'h10, 8'h20, 1'b0);
      finish_add(0, 1'b0);

      for (int k = 0; k < 6; k++) begin
         start(W'($urandom), W'($urandom), 1'b0);
         finish_add(k % 3, 1'b0);
      end

`ifdef SERIAL_ADD_CIN_EN
      start(8'hFF, 8'h00, 1'b1);
      finish_add(0, 1'b0);
      start(8'h01, 8'h01, 1'b1);
      finish_add(0, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
